// File: rtl/int_ctrl.sv
// Prioritised, vectored interrupt controller: edge-detects sources, masks,
// arbitrates lowest index first and hands the winner to the CU via req/ack.
module int_ctrl #(
  parameter int unsigned     NSRC      = 4,
  parameter logic [7:0]      VEC_BASE  = 8'hF0,
  parameter int unsigned     VEC_SHIFT = 2,
  parameter logic [NSRC-1:0] MASK_RST  = '1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_in,
  input  logic [NSRC-1:0] mask_set,
  input  logic [NSRC-1:0] mask_clr,
  input  logic            if_en,
  input  logic            int_ack,
  input  logic            iret,
  output logic            int_req,
  output logic [2:0]      int_num,
  output logic [7:0]      int_address,
  output logic [NSRC-1:0] pending,
  output logic [NSRC-1:0] mask,
  output logic            in_service
);

  localparam int unsigned NUM_W  = 3;
  localparam int unsigned ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [NSRC-1:0]     irq_d;
  logic [NSRC-1:0]     rise;
  logic [NSRC-1:0]     eligible;
  logic [NSRC-1:0]     clr_vec;
  logic [NSRC-1:0]     pending_nxt;
  logic [NSRC-1:0]     mask_nxt;
  logic [NUM_W-1:0]    winner;
  logic [ADDR_W-1:0]   winner_addr;
  logic [NUM_W-1:0]    int_num_nxt;
  logic [ADDR_W-1:0]   int_address_nxt;
  logic                int_req_nxt;
  logic                in_service_nxt;

  assign rise     = irq_in & ~irq_d;
  assign eligible = pending & ~mask;

  // Lowest set index wins; descending scan leaves the lowest one last.
  always_comb begin
    winner = '0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (eligible[i]) winner = NUM_W'(i);
    end
  end

  assign winner_addr = ADDR_W'(32'(VEC_BASE) + (32'(winner) << VEC_SHIFT));

  // Next-state, request outputs and the acknowledge clear vector.
  always_comb begin
    state_nxt       = state;
    int_req_nxt     = int_req;
    int_num_nxt     = int_num;
    int_address_nxt = int_address;
    in_service_nxt  = in_service;
    clr_vec         = '0;
    case (state)
      IDLE: begin
        if (if_en && (|eligible)) begin
          state_nxt       = REQ;
          int_req_nxt     = 1'b1;
          int_num_nxt     = winner;
          int_address_nxt = winner_addr;
        end
      end
      REQ: begin
        if (int_ack) begin
          for (int i = 0; i < int'(NSRC); i++) begin
            if (int_num == NUM_W'(i)) clr_vec[i] = 1'b1;
          end
          int_req_nxt    = 1'b0;
          in_service_nxt = 1'b1;
          state_nxt      = SERVICE;
        end else if (!if_en) begin
          int_req_nxt = 1'b0;
          state_nxt   = IDLE;
        end
      end
      SERVICE: begin
        if (iret) begin
          in_service_nxt = 1'b0;
          state_nxt      = IDLE;
        end
      end
      default: begin
        state_nxt      = IDLE;
        int_req_nxt    = 1'b0;
        in_service_nxt = 1'b0;
      end
    endcase
  end

  // A fresh edge on the acknowledged source beats the clear.
  assign pending_nxt = (pending & ~clr_vec) | rise;
  assign mask_nxt    = (mask & ~mask_clr) | mask_set;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      irq_d       <= '0;
      pending     <= '0;
      mask        <= MASK_RST;
      int_req     <= 1'b0;
      int_num     <= '0;
      int_address <= VEC_BASE;
      in_service  <= 1'b0;
    end else begin
      state       <= state_nxt;
      irq_d       <= irq_in;
      pending     <= pending_nxt;
      mask        <= mask_nxt;
      int_req     <= int_req_nxt;
      int_num     <= int_num_nxt;
      int_address <= int_address_nxt;
      in_service  <= in_service_nxt;
    end
  end

endmodule
